debug_word_scanner: RTL
=======================

// Module: debug_word_scanner
// PURPOSE
// Sequential, parametrised debug-word selector for the FPGA front panel.
// Holds a channel/index cursor (e.g. ch0 = instruction mem, ch1 = register file, ch2 = data mem).
// Fetches the addressed word from per-channel synchronous read ports; moves the cursor on
// pre-debounced button pulses or an auto-scan timer; re-reads periodically so the display tracks
// CPU writes. Sits between the MIPS core debug ports and the 7-segment/LCD formatter.
// PARAMETERS
// NUM_CH      3                          number of source channels (>=1); CH_W = max(1,$clog2(NUM_CH))
// DATA_W      32                         word width
// ADDR_W      10                         cursor/address width
// CH_DEPTHS   {11'd1024,11'd32,11'd256}  packed NUM_CH fields of ADDR_W+1 bits, ch0 in LSBs;
//                                        word count per channel, each 1..2**ADDR_W
// RD_LAT      1                          source read latency in cycles (>=1)
// AUTO_PERIOD 50_000_000                 cycles between auto-steps / refreshes (>=2)
// PORTS
// clock        in   1               system clock, all logic on rising edge
// reset        in   1               asynchronous, active-high
// btn_next     in   1               1-cycle pulse: index+1
// btn_prev     in   1               1-cycle pulse: index-1
// btn_chan     in   1               1-cycle pulse: next channel
// auto_en      in   1               level: auto-scan (timer acts as btn_next)
// rd_req       out  1               read strobe to sources, 1 cycle per fetch
// rd_chan      out  CH_W            channel being read (== cur_chan)
// rd_addr      out  ADDR_W          address being read (== cur_index)
// rd_data_all  in   NUM_CH*DATA_W   all channel read buses, ch0 in LSBs
// word         out  DATA_W          last fetched word
// word_valid   out  1               word matches current cursor
// cur_chan     out  CH_W            cursor channel
// cur_index    out  ADDR_W          cursor index
// BEHAVIOUR
// - Reset values: word=0, word_valid=0, cur_chan=0, cur_index=0, rd_req=0, timer=0, state=ISSUE.
//   Reset asserted mid-fetch aborts the fetch; no partial word load.
// - FSM IDLE/ISSUE/WAIT. ISSUE: rd_req=1 for exactly 1 cycle -> WAIT. WAIT counts RD_LAT cycles;
//   in the cycle rd_req+RD_LAT, word <= rd_data_all[cur_chan*DATA_W +: DATA_W]; word_valid <= 1;
//   -> IDLE. First fetch (ch0, idx0) starts in the first cycle after reset release.
// - Events are sampled only in IDLE; pulses during ISSUE/WAIT are dropped (not queued).
// - Simultaneous pulses: btn_chan > btn_next > btn_prev; only the winner acts, others dropped.
// - btn_next: index = (index == depth-1) ? 0 : index+1. btn_prev: index = (index == 0) ? depth-1 : index-1.
//   depth = CH_DEPTHS field of cur_chan.
// - btn_chan: chan = (chan == NUM_CH-1) ? 0 : chan+1; index kept if < new depth, else 0.
// - Cursor event in IDLE cycle t: cursor updated and word_valid=0 from t+1; ISSUE at t+1;
//   word/word_valid=1 visible at t+2+RD_LAT.
// - Timer counts in IDLE only; cleared on any accepted event and on leaving IDLE.
//   At AUTO_PERIOD-1: if auto_en -> internal next (same as btn_next, lowest priority);
//   else refresh -> ISSUE with cursor unchanged and word_valid held at 1.
// - A button pulse in the same cycle as timer expiry wins; the timer clears.
// - rd_chan/rd_addr driven from the cursor registers; stable through ISSUE/WAIT.
// - CH_DEPTHS field == 1: next/prev keep index 0 but still trigger a fetch.
// TESTING
// T1 reset release, RD_LAT=1, ch0[0]=32'hDEAD0000 -> rd_req at cycle 1; word=DEAD0000, word_valid=1 at cycle 3.
// T2 ch1 (depth 32), idx 31, btn_next -> idx 0, rd_addr=0; then btn_prev -> idx 31.
// T3 ch2, idx 500, btn_chan -> ch0 (depth 256), idx 0; from ch0 idx 7, btn_chan -> ch1 idx 7.
// T4 btn_chan+btn_next same cycle -> only channel changes; btn_next during WAIT -> dropped, idx unchanged.
// T5 AUTO_PERIOD=8, auto_en=1 -> idx steps 0,1,2 every 8 idle cycles; auto_en=0 and ch1[3]
//    changed 5->9 -> refresh shows 9, word_valid never drops.
// T6 reset asserted in WAIT -> word=0, word_valid=0, cursor 0, no load; refetch of ch0 idx0 after release.

Source files
------------

// File: rtl/debug_word_scanner.sv
// rtl/debug_word_scanner.sv - front-panel debug word selector with cursor, fetch FSM and auto-scan timer
module debug_word_scanner #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter logic [NUM_CH*(ADDR_W+1)-1:0] CH_DEPTHS = {11'd1024, 11'd32, 11'd256},
    parameter int RD_LAT = 1,
    parameter int AUTO_PERIOD = 50_000_000,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     btn_next,
    input  logic                     btn_prev,
    input  logic                     btn_chan,
    input  logic                     auto_en,
    output logic                     rd_req,
    output logic [CH_W-1:0]          rd_chan,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [NUM_CH*DATA_W-1:0] rd_data_all,
    output logic [DATA_W-1:0]        word,
    output logic                     word_valid,
    output logic [CH_W-1:0]          cur_chan,
    output logic [ADDR_W-1:0]        cur_index
);

    localparam int DW = ADDR_W + 1;
    localparam int TW = $clog2(AUTO_PERIOD);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic                started;
    logic [LW-1:0]       lat_cnt;
    logic [TW-1:0]       timer;

    logic [DATA_W-1:0]   sel_data;
    logic [DW-1:0]       sel_depth, sel_last, nxt_depth;
    logic [CH_W-1:0]     chan_inc;
    logic [ADDR_W-1:0]   idx_inc, idx_dec, idx_keep;
    logic                expire, do_chan, do_next, do_prev, load;

    // Per-channel mux of read data and channel depths for the current and next channel
    always_comb begin
        sel_data  = '0;
        sel_depth = '0;
        nxt_depth = '0;
        chan_inc  = (cur_chan == CH_W'(NUM_CH - 1)) ? '0 : cur_chan + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_chan == CH_W'(i)) begin
                sel_data  = rd_data_all[i*DATA_W +: DATA_W];
                sel_depth = CH_DEPTHS[i*DW +: DW];
            end
            if (chan_inc == CH_W'(i)) begin
                nxt_depth = CH_DEPTHS[i*DW +: DW];
            end
        end
        sel_last = sel_depth - 1'b1;
        idx_inc  = ({1'b0, cur_index} == sel_last) ? '0 : cur_index + 1'b1;
        idx_dec  = (cur_index == '0) ? sel_last[ADDR_W-1:0] : cur_index - 1'b1;
        idx_keep = ({1'b0, cur_index} < nxt_depth) ? cur_index : '0;
    end

    // Next-state and event arbitration; events only count while idle
    always_comb begin
        state_d = state_q;
        do_chan = 1'b0;
        do_next = 1'b0;
        do_prev = 1'b0;
        load    = 1'b0;
        expire  = (timer == TW'(AUTO_PERIOD - 1));
        case (state_q)
            IDLE: begin
                if (btn_chan)
                    do_chan = 1'b1;
                else if (btn_next)
                    do_next = 1'b1;
                else if (btn_prev)
                    do_prev = 1'b1;
                else if (expire && auto_en)
                    do_next = 1'b1;
                // an expiry without auto_en is a plain refresh of the same cursor
                if (do_chan || do_next || do_prev || expire)
                    state_d = ISSUE;
            end
            ISSUE: begin
                // hold off the very first strobe until one clock after reset release
                if (started)
                    state_d = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LW'(RD_LAT - 1)) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= ISSUE;
        else
            state_q <= state_d;
    end

    // Marks the first clock after reset so the initial fetch strobes cleanly
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            started <= 1'b0;
        else
            started <= 1'b1;
    end

    // Read latency counter, runs only while waiting for source data
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lat_cnt <= '0;
        else if (state_q == WAIT)
            lat_cnt <= lat_cnt + 1'b1;
        else
            lat_cnt <= '0;
    end

    // Auto-step / refresh timer: counts idle cycles, clears on any exit from idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timer <= '0;
        else if (state_q == IDLE && state_d == IDLE)
            timer <= timer + 1'b1;
        else
            timer <= '0;
    end

    // Cursor moves and word capture; a cursor move invalidates the shown word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_chan   <= '0;
            cur_index  <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (do_chan) begin
            cur_chan   <= chan_inc;
            cur_index  <= idx_keep;
            word_valid <= 1'b0;
        end else if (do_next) begin
            cur_index  <= idx_inc;
            word_valid <= 1'b0;
        end else if (do_prev) begin
            cur_index  <= idx_dec;
            word_valid <= 1'b0;
        end else if (load) begin
            word       <= sel_data;
            word_valid <= 1'b1;
        end
    end

    assign rd_req  = started && (state_q == ISSUE);
    assign rd_chan = cur_chan;
    assign rd_addr = cur_index;

endmodule
